// File: rtl/rsa_algorithm_pkg.sv
// ----------------------------------------------------------------------------
// rsa_algorithm_pkg
// Shared definitions for the Montgomery modular-exponentiation datapath.
//   mm_state_e      : top-level sequencing states of the exponentiation control
//   mm_phase_e      : sub-phase of every multiply state (ISSUE / WAIT)
//   mm_op_latency() : cycles one Montgomery multiply occupies, ISSUE cycle to
//                     the first cycle of the following state (K/2 radix-4
//                     iterations plus the ISSUE and capture cycles)
// ----------------------------------------------------------------------------
package rsa_algorithm_pkg;

    typedef enum logic [2:0] {
        IDLE,
        PRE_X,
        PRE_A,
        SQR,
        MUL,
        POST,
        DONE
    } mm_state_e;

    typedef enum logic {
        PH_ISSUE,
        PH_WAIT
    } mm_phase_e;

    // Radix-4 multiplier consumes two operand bits per iteration, so K/2
    // iterations, plus one ISSUE cycle and one result-capture cycle.
    function automatic int mm_op_latency(input int k);
        return k / 2 + 2;
    endfunction

endpackage

// File: rtl/mm_r2mm_2n.sv
// ----------------------------------------------------------------------------
// mm_r2mm_2n
// Radix-4 Montgomery multiplier: res = a * b * 2^-K mod m (fully reduced when
// a, b < m and m is odd).
//   clk, rst_n : clock, asynchronous active-low reset
//   req        : a job starts on a rising edge of req (low->high)
//   a, b, m    : operands and odd modulus; read on every iteration, so they
//                must be held stable by the caller until val
//   res        : product, valid while val is high
//   val        : one-cycle pulse, K/2+1 cycles after the req-high cycle
// ----------------------------------------------------------------------------
module mm_r2mm_2n
    import rsa_algorithm_pkg::*;
#(
    parameter int K = 2048
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         req,
    input  logic [K-1:0] a,
    input  logic [K-1:0] b,
    input  logic [K-1:0] m,
    output logic [K-1:0] res,
    output logic         val
);

    // Three guard bits: the running sum stays below 8*2^K in every iteration.
    localparam int W    = K + 3;
    localparam int ITER = mm_op_latency(K) - 2;
    localparam int CW   = (ITER > 1) ? $clog2(ITER) : 1;

    logic [W-1:0]  acc_q;
    logic [CW-1:0] cnt_q;
    logic          run_q;
    logic          req_q;

    logic [W-1:0]  b_ext;
    logic [W-1:0]  m_ext;
    logic [W-1:0]  add_b;
    logic [W-1:0]  add_m;
    logic [W-1:0]  sum1;
    logic [W-1:0]  sum2;
    logic [W-1:0]  nxt;
    logic [W-1:0]  red;
    logic [1:0]    digit;
    logic [1:0]    mprime;
    logic [1:0]    q;

    // One radix-4 Montgomery step on the current digit of a. The quotient
    // digit q makes the low two bits of sum2 zero, so the shift is exact.
    // -m^-1 mod 4 is 3 when m = 1 (mod 4) and 1 when m = 3 (mod 4).
    always_comb begin
        b_ext  = {3'b000, b};
        m_ext  = {3'b000, m};
        mprime = {~m[1], 1'b1};
        digit  = 2'(a >> {cnt_q, 1'b0});

        add_b = '0;
        if (digit[0]) add_b = b_ext;
        if (digit[1]) add_b = add_b + (b_ext << 1);
        sum1 = acc_q + add_b;

        q = sum1[1:0] * mprime;

        add_m = '0;
        if (q[0]) add_m = m_ext;
        if (q[1]) add_m = add_m + (m_ext << 1);
        sum2 = sum1 + add_m;

        nxt = sum2 >> 2;
        red = (nxt >= m_ext) ? (nxt - m_ext) : nxt;
    end

    // Start on a req rising edge while idle, iterate K/2 times, then publish
    // the final conditionally-subtracted result with a single val pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
            cnt_q <= '0;
            run_q <= 1'b0;
            req_q <= 1'b0;
            res   <= '0;
            val   <= 1'b0;
        end else begin
            req_q <= req;
            val   <= 1'b0;
            if (run_q) begin
                acc_q <= nxt;
                cnt_q <= cnt_q + CW'(1);
                if (cnt_q == CW'(ITER - 1)) begin
                    run_q <= 1'b0;
                    val   <= 1'b1;
                    res   <= K'(red);
                end
            end else if (req && !req_q) begin
                run_q <= 1'b1;
                cnt_q <= '0;
                acc_q <= '0;
            end
        end
    end

endmodule

// File: rtl/mm_modexp_ctrl.sv
// ----------------------------------------------------------------------------
// mm_modexp_ctrl
// Left-to-right square-and-multiply modular exponentiation in the Montgomery
// domain, sequencing a single mm_r2mm_2n multiplier.
//   clk, rst_n : clock, asynchronous active-low reset (also resets multiplier)
//   x          : base (x < m)
//   e          : exponent, E bits
//   m          : odd modulus
//   r2         : R^2 mod m, R = 2^K
//   req        : start, sampled only in IDLE
//   res        : x^e mod m, updated on entry to DONE and held until next DONE
//   val        : one-cycle pulse qualifying res (the DONE cycle)
//   busy       : high from the cycle after acceptance through the val cycle
// ----------------------------------------------------------------------------
module mm_modexp_ctrl
    import rsa_algorithm_pkg::*;
#(
    parameter int K = 2048,
    parameter int E = K
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [K-1:0] x,
    input  logic [E-1:0] e,
    input  logic [K-1:0] m,
    input  logic [K-1:0] r2,
    input  logic         req,
    output logic [K-1:0] res,
    output logic         val,
    output logic         busy
);

    localparam int IW = (E > 1) ? $clog2(E) : 1;
    localparam logic [IW-1:0] IDX_TOP = IW'(E - 1);
    localparam logic [K-1:0]  ONE     = K'(1);

    mm_state_e     state;
    mm_phase_e     phase;

    logic [K-1:0]  x_q;
    logic [E-1:0]  e_q;
    logic [K-1:0]  m_q;
    logic [K-1:0]  r2_q;
    logic [K-1:0]  acc;
    logic [K-1:0]  xm;
    logic [IW-1:0] bit_idx;

    logic          mul_req;
    logic [K-1:0]  mul_a;
    logic [K-1:0]  mul_b;
    logic [K-1:0]  mul_res;
    logic          mul_val;

    // Operand selection follows the state alone; acc and xm only change on a
    // capture edge, so the operands stay constant for the whole multiply.
    always_comb begin
        mul_a = acc;
        mul_b = acc;
        case (state)
            PRE_X: begin
                mul_a = x_q;
                mul_b = r2_q;
            end
            PRE_A: begin
                mul_a = ONE;
                mul_b = r2_q;
            end
            MUL: begin
                mul_a = acc;
                mul_b = xm;
            end
            POST: begin
                mul_a = acc;
                mul_b = ONE;
            end
            default: begin
                mul_a = acc;
                mul_b = acc;
            end
        endcase
    end

    mm_r2mm_2n #(
        .K (K)
    ) u_mul (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (mul_req),
        .a     (mul_a),
        .b     (mul_b),
        .m     (m_q),
        .res   (mul_res),
        .val   (mul_val)
    );

    // Main sequencer. Every multiply state starts in ISSUE with mul_req
    // already high (set on the entering edge), drops it after one cycle so
    // the next operation sees a fresh rising edge, and waits in WAIT for the
    // multiplier result. The bit index only moves once a bit is fully done:
    // after SQR on a zero bit, or after MUL on a one bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            phase   <= PH_ISSUE;
            mul_req <= 1'b0;
            x_q     <= '0;
            e_q     <= '0;
            m_q     <= '0;
            r2_q    <= '0;
            acc     <= '0;
            xm      <= '0;
            bit_idx <= IDX_TOP;
            res     <= '0;
            val     <= 1'b0;
            busy    <= 1'b0;
        end else begin
            val <= 1'b0;
            case (state)
                IDLE: begin
                    if (req) begin
                        x_q     <= x;
                        e_q     <= e;
                        m_q     <= m;
                        r2_q    <= r2;
                        bit_idx <= IDX_TOP;
                        state   <= PRE_X;
                        phase   <= PH_ISSUE;
                        mul_req <= 1'b1;
                        busy    <= 1'b1;
                    end
                end

                PRE_X, PRE_A, SQR, MUL, POST: begin
                    if (phase == PH_ISSUE) begin
                        mul_req <= 1'b0;
                        phase   <= PH_WAIT;
                    end else if (mul_val) begin
                        phase <= PH_ISSUE;
                        case (state)
                            PRE_X: begin
                                xm      <= mul_res;
                                state   <= PRE_A;
                                mul_req <= 1'b1;
                            end
                            PRE_A: begin
                                acc     <= mul_res;
                                state   <= SQR;
                                mul_req <= 1'b1;
                            end
                            SQR: begin
                                acc     <= mul_res;
                                mul_req <= 1'b1;
                                if (e_q[bit_idx]) begin
                                    state <= MUL;
                                end else if (bit_idx == '0) begin
                                    state <= POST;
                                end else begin
                                    bit_idx <= bit_idx - IW'(1);
                                    state   <= SQR;
                                end
                            end
                            MUL: begin
                                acc     <= mul_res;
                                mul_req <= 1'b1;
                                if (bit_idx == '0) begin
                                    state <= POST;
                                end else begin
                                    bit_idx <= bit_idx - IW'(1);
                                    state   <= SQR;
                                end
                            end
                            default: begin
                                res     <= mul_res;
                                val     <= 1'b1;
                                state   <= DONE;
                                mul_req <= 1'b0;
                            end
                        endcase
                    end
                end

                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end

                default: begin
                    state   <= IDLE;
                    phase   <= PH_ISSUE;
                    mul_req <= 1'b0;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mm_modexp_ctrl.sv
// ----------------------------------------------------------------------------
// tb_mm_modexp_ctrl
// Directed vectors with hand-computed results for mm_modexp_ctrl at K=E=16,
// modulus 0xFFF1 (prime), R^2 mod m = 0x00E1.
// ----------------------------------------------------------------------------
module tb_mm_modexp_ctrl;

    localparam int K = 16;
    localparam int E = 16;
    localparam int L = K / 2 + 2;
    localparam logic [K-1:0] MOD = 16'hFFF1;
    localparam logic [K-1:0] R2V = 16'h00E1;

    logic         clk;
    logic         rst_n;
    logic [K-1:0] x;
    logic [E-1:0] e;
    logic [K-1:0] m;
    logic [K-1:0] r2;
    logic         req;
    logic [K-1:0] res;
    logic         val;
    logic         busy;

    int vecCount  = 0;
    int missCount = 0;
    int valPulses = 0;
    int jobCycle  = 0;
    int pulseBase = 0;

    mm_modexp_ctrl #(
        .K (K),
        .E (E)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .x     (x),
        .e     (e),
        .m     (m),
        .r2    (r2),
        .req   (req),
        .res   (res),
        .val   (val),
        .busy  (busy)
    );

    // Free-running 10-unit clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count every cycle in which val is high, sampled mid-cycle
    always @(negedge clk) begin
        if (val) valPulses++;
    end

    // Single comparison point: counts the vector and reports any miscompare
    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vecCount++;
        if (got !== exp) begin
            missCount++;
            $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance to the next falling edge, tracking cycles since acceptance
    task automatic stepCycle();
        @(negedge clk);
        jobCycle++;
    endtask

    // Called on a falling edge with the DUT idle: present a job, let the next
    // rising edge accept it, and return on the falling edge of cycle 1
    task automatic applyStimulus(input logic [K-1:0] xv, input logic [E-1:0] ev,
                                 input logic [K-1:0] mv, input logic [K-1:0] r2v);
        x   = xv;
        e   = ev;
        m   = mv;
        r2  = r2v;
        req = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req      = 1'b0;
        jobCycle = 1;
    endtask

    // Wait (bounded) for val, then check arrival cycle, result and busy
    task automatic waitResult(input string tag, input int expCycle, input logic [K-1:0] expRes);
        logic got;
        got = 1'b0;
        while (jobCycle < 2000) begin
            if (val) begin
                got = 1'b1;
                break;
            end
            stepCycle();
        end
        checkOutput({tag, "_val_seen"}, {31'd0, got}, 32'd1);
        if (got) begin
            checkOutput({tag, "_cycle"}, jobCycle, expCycle);
            checkOutput({tag, "_res"}, {16'd0, res}, {16'd0, expRes});
            checkOutput({tag, "_busy_at_val"}, {31'd0, busy}, 32'd1);
        end
    endtask

    function automatic int expCycles(input logic [E-1:0] ev);
        return (3 + E + $countones(ev)) * L + 1;
    endfunction

    initial begin
        rst_n = 1'b0;
        req   = 1'b0;
        x     = '0;
        e     = '0;
        m     = '0;
        r2    = '0;

        // Reset state
        repeat (3) @(negedge clk);
        checkOutput("reset_res", {16'd0, res}, 32'd0);
        checkOutput("reset_val", {31'd0, val}, 32'd0);
        checkOutput("reset_busy", {31'd0, busy}, 32'd0);
        rst_n = 1'b1;

        // 2^10 mod 0xFFF1 = 0x0400
        pulseBase = valPulses;
        applyStimulus(16'd2, 16'd10, MOD, R2V);
        checkOutput("pow2_busy_c1", {31'd0, busy}, 32'd1);
        waitResult("pow2", expCycles(16'd10), 16'h0400);

        // req raised in DONE is ignored; the following IDLE cycle accepts it
        x   = 16'd3;
        e   = 16'd2;
        req = 1'b1;
        stepCycle();
        checkOutput("pow2_val_one_cycle", {31'd0, val}, 32'd0);
        checkOutput("pow2_busy_idle", {31'd0, busy}, 32'd0);
        checkOutput("pow2_res_hold", {16'd0, res}, 32'h0400);
        checkOutput("pow2_pulses", valPulses - pulseBase, 32'd1);
        applyStimulus(16'd3, 16'd2, MOD, R2V);
        checkOutput("reentry_busy_c1", {31'd0, busy}, 32'd1);
        waitResult("reentry", expCycles(16'd2), 16'h0009);
        stepCycle();

        // Fermat: 3^(p-1) mod p = 1
        applyStimulus(16'd3, 16'hFFF0, MOD, R2V);
        waitResult("fermat", expCycles(16'hFFF0), 16'h0001);
        stepCycle();

        // e = 0 gives 1
        applyStimulus(16'h1234, 16'd0, MOD, R2V);
        waitResult("exp0", 191, 16'h0001);
        stepCycle();

        // Second req mid-job with a different base is ignored
        pulseBase = valPulses;
        applyStimulus(16'd5, 16'd3, MOD, R2V);
        while (jobCycle < 50) stepCycle();
        x   = 16'd7;
        req = 1'b1;
        stepCycle();
        req = 1'b0;
        waitResult("ignore", expCycles(16'd3), 16'h007D);
        repeat (4) stepCycle();
        checkOutput("ignore_pulses", valPulses - pulseBase, 32'd1);
        checkOutput("ignore_busy_after", {31'd0, busy}, 32'd0);

        // Reset mid-job: outputs clear at once, abandoned job never reports
        pulseBase = valPulses;
        applyStimulus(16'd2, 16'd10, MOD, R2V);
        while (jobCycle < 100) stepCycle();
        rst_n = 1'b0;
        #1;
        checkOutput("abort_busy", {31'd0, busy}, 32'd0);
        checkOutput("abort_val", {31'd0, val}, 32'd0);
        checkOutput("abort_res", {16'd0, res}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(16'd2, 16'd10, MOD, R2V);
        checkOutput("post_reset_busy_c1", {31'd0, busy}, 32'd1);
        waitResult("post_reset", expCycles(16'd10), 16'h0400);
        stepCycle();
        checkOutput("post_reset_pulses", valPulses - pulseBase, 32'd1);

        // Degenerate modulus m = 1: everything reduces to 0
        applyStimulus(16'd0, 16'd5, 16'd1, 16'd0);
        waitResult("mod1", expCycles(16'd5), 16'h0000);
        stepCycle();

        // Zero base with nonzero exponent
        applyStimulus(16'd0, 16'd7, MOD, R2V);
        waitResult("base0", expCycles(16'd7), 16'h0000);
        stepCycle();

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

endmodule

// File: doc/mm_modexp_ctrl.md
MM_MODEXP_CTRL -- requirements
Module: mm_modexp_ctrl

Interface
REQ-001 SHALL have parameter K, default 2048: operand and modulus width; even, K<8191.
REQ-002 SHALL have parameter E, default K: exponent width, 1..K.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-005 SHALL have port x, input, K bits: base; x < m.
REQ-006 SHALL have port e, input, E bits: exponent.
REQ-007 SHALL have port m, input, K bits: odd modulus.
REQ-008 SHALL have port r2, input, K bits: R^2 mod m, where R = 2^K.
REQ-009 SHALL have port req, input, 1 bit: start; sampled only while idle.
REQ-010 SHALL have port res, output, K bits: x^e mod m, fully reduced.
REQ-011 SHALL have port val, output, 1 bit: one-cycle pulse qualifying res.
REQ-012 SHALL have port busy, output, 1 bit: high from the cycle after req is accepted until the cycle of val, inclusive.

Function
REQ-013 SHALL compute left-to-right square-and-multiply in the Montgomery domain.
- Sequence: xm=MM(x,r2); acc=MM(1,r2); for i=E-1 down to 0: acc=MM(acc,acc), then acc=MM(acc,xm) if e[i]; res=MM(acc,1).
REQ-014 SHALL latch x, e, m and r2 on the accepting edge, and SHALL ignore input changes while busy.
REQ-015 SHALL use states IDLE, PRE_X, PRE_A, SQR, MUL, POST and DONE.
- Transitions: IDLE->PRE_X on req; PRE_X->PRE_A->SQR.
- SQR->MUL if e[i]=1, otherwise SQR->next bit.
- MUL->next bit.
- Next bit: SQR while bits remain, otherwise POST.
- POST->DONE->IDLE.
REQ-016 SHALL divide each multiply state into ISSUE and WAIT.
- ISSUE: drives the multiplier req high for exactly one cycle with the operands stable.
- WAIT: holds the operands until the multiplier val, then captures the multiplier res in the same cycle.
REQ-017 SHALL hold the multiplier operands constant from ISSUE until val, because the multiplier reads them on every iteration.
REQ-018 SHALL drive the multiplier req low for at least one cycle between consecutive operations, because the multiplier starts only on a req rising edge.
REQ-019 SHALL make each multiplication occupy exactly K/2+2 cycles, from the ISSUE cycle to the first cycle of the following state.
REQ-020 SHALL raise val exactly (3+E+popcount(e))*(K/2+2)+1 cycles after the accepting edge.
REQ-021 SHALL use a bit index that counts down from E-1 and is decremented only on leaving SQR with e[i]=0, or on leaving MUL.
REQ-022 SHALL update res only in DONE, hold res until the next DONE, and hold val high for one cycle only.
REQ-023 SHALL make req asserted while busy, or in the DONE cycle, have no effect.
- A req arriving in the same cycle that IDLE is re-entered SHALL be accepted.
REQ-024 SHALL handle the boundary cases as follows.
- e=0: res = 1 mod m (0 when m=1).
- x=0 with e!=0: res = 0.
REQ-025 SHALL NOT check that m is odd, that x < m, or that r2 is correct; results under violated preconditions are unspecified but SHALL NOT hang the FSM.

Reset
REQ-026 SHALL, with rst_n low, immediately force: state IDLE, res 0, val 0, busy 0, multiplier req 0, acc 0, xm 0, bit index E-1.
REQ-027 SHALL reset the multiplier instance from the same rst_n, so that a reset mid-operation abandons the job without a val pulse.
REQ-028 SHALL accept a new req on the first edge after rst_n deasserts.

Structure
REQ-029 SHALL place the state encodings and the per-operation latency constant (K/2+2) in the shared rsa_algorithm package.
REQ-030 SHALL instantiate exactly one sub-module: mm_r2mm_2n, with parameter K, sharing clk and rst_n; operands are muxed by state.

Verification
REQ-031 SHALL verify, with K=16, m=0xFFF1, r2=0x00E1, x=2, e=10: res=0x0400; val arrives at cycle (3+16+2)*10+1 = 211.
REQ-032 SHALL verify, with K=16, m=0xFFF1, x=3, e=0xFFF0: res=0x0001 (Fermat).
REQ-033 SHALL verify, with K=16, m=0xFFF1, x=0x1234, e=0: res=0x0001 at cycle 19*10+1 = 191.
REQ-034 SHALL verify that with x=5, e=3 running, a second req at cycle 50 with x=7 is ignored: res=0x007D, and exactly one val.
REQ-035 SHALL verify that rst_n pulsed low at cycle 100 of a job gives: busy=0 and val=0 immediately, and a fresh job with x=2, e=10 still returns 0x0400.
REQ-036 SHALL verify, with K=16, m=1, x=0, e=5: res=0x0000 and val still asserted.
